// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the start/done ALU responder: opcode and
//               FSM state encodings, latency-counter width, and a helper that
//               classifies multiply opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode encoding; 3'b101..3'b111 are undefined and treated like no_op.
  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXEC     = 2'b01,
    ST_DONE     = 2'b10,
    ST_WAIT_LOW = 2'b11
  } state_t;

  // Wide enough for the largest legal multiply latency (8).
  localparam int CNT_W = 4;

  function automatic logic is_mul(input op_t o);
    return (o == mul_op);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_pipe
// Description : MUL_LATENCY-stage multiply pipeline. The product is formed in
//               front of the first stage and then shifted through; a valid
//               bit travels alongside the data.
// Ports       : clk, reset_n      - clock, async active-low reset
//               in_valid, a, b    - operands, sampled when in_valid is high
//               out_valid, product- last-stage valid and 2*WIDTH product
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_pipe #(
  parameter int WIDTH       = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] r_prod [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] r_vld;
  logic [2*WIDTH-1:0] w_prod;

  assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld[0]  <= 1'b0;
      r_prod[0] <= '0;
    end else begin
      r_vld[0]  <= in_valid;
      r_prod[0] <= w_prod;
    end
  end

  generate
    for (genvar gi = 1; gi < MUL_LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_vld[gi]  <= 1'b0;
          r_prod[gi] <= '0;
        end else begin
          r_vld[gi]  <= r_vld[gi-1];
          r_prod[gi] <= r_prod[gi-1];
        end
      end
    end
  endgenerate

  assign out_valid = r_vld[MUL_LATENCY-1];
  assign product   = r_prod[MUL_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : alu_responder
// Description : Responder end of the start/done ALU command protocol. A
//               command (op, A, B) is captured when start is seen in IDLE;
//               the result is registered and done pulses for one cycle after
//               1 edge (logic/add) or MUL_LATENCY edges (multiply).
// Ports       : clk, reset_n   - clock, async active-low reset
//               start, op, A, B- command request and operands
//               done           - one-cycle completion pulse
//               result         - registered 2*WIDTH result, held between cmds
//               busy           - command in progress / waiting for start low
//               proto_err      - sticky: inputs changed while start held
// Revision    : 1.0 - initial release
// ============================================================================
module alu_responder
  import alu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MUL_LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  op_t                op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               proto_err
);

  state_t             r_state;
  state_t             w_state_nxt;
  op_t                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic               r_proto_err;
  logic [2*WIDTH-1:0] w_alu_res;
  logic               w_accept;
  logic               w_last;
  logic               w_done;
  logic               w_busy;
  logic               w_mul_valid;
  logic [2*WIDTH-1:0] w_mul_product;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_state == ST_EXEC) && (r_cnt == CNT_W'(1));

  // The pipe's first stage samples A/B on the same edge as r_a/r_b, so it
  // holds exactly the captured operands and the product is ready for E_L.
  alu_mul_pipe #(
    .WIDTH       (WIDTH),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (w_accept && is_mul(op)),
    .a         (A),
    .b         (B),
    .out_valid (w_mul_valid),
    .product   (w_mul_product)
  );

  // Result selection; no_op and undefined opcodes keep the previous result.
  always_comb begin
    w_alu_res = r_result;
    case (r_op)
      add_op: w_alu_res = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
      and_op: w_alu_res = {{WIDTH{1'b0}}, r_a & r_b};
      xor_op: w_alu_res = {{WIDTH{1'b0}}, r_a ^ r_b};
      mul_op: if (w_mul_valid) w_alu_res = w_mul_product;
      default: w_alu_res = r_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = start ? ST_WAIT_LOW : ST_IDLE;
      end
      ST_WAIT_LOW: begin
        if (!start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= no_op;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= op;
        r_a   <= A;
        r_b   <= B;
        r_cnt <= is_mul(op) ? CNT_W'(MUL_LATENCY) : CNT_W'(1);
      end else if (r_state == ST_EXEC) begin
        if (w_last) r_result <= w_alu_res;
        else        r_cnt    <= r_cnt - CNT_W'(1);
      end
      if (((r_state == ST_EXEC) || (r_state == ST_DONE)) && start &&
          ((op != r_op) || (A != r_a) || (B != r_b)))
        r_proto_err <= 1'b1;
    end
  end

  assign done      = w_done;
  assign busy      = w_busy;
  assign result    = r_result;
  assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_responder
// Description : Directed self-checking bench for alu_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_responder;
  import alu_pkg::*;

  localparam int WIDTH       = 8;
  localparam int MUL_LATENCY = 3;

  logic               clk;
  logic               reset_n;
  logic               start;
  op_t                op;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               proto_err;

  int errors = 0;
  int checks = 0;

  alu_responder #(
    .WIDTH       (WIDTH),
    .MUL_LATENCY (MUL_LATENCY)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full handshake: raise start, count latency, check done/result, drop start.
  task automatic do_cmd(input string tag, input op_t o, input logic [7:0] a,
                        input logic [7:0] b, input int lat, input logic [15:0] exp);
    op = o; A = a; B = b; start = 1'b1;
    tick();                                   // E0
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_done_e0"}, done, 0);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_done_early"}, done, 0);
    end
    tick();                                   // E_L
    chk({tag, "_done"}, done, 1);
    chk({tag, "_result"}, result, exp);
    start = 1'b0;
    tick();
    chk({tag, "_done_low"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_result_hold"}, result, exp);
    tick();                                   // idle spacing edge
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = no_op; A = '0; B = '0;
    tick(); tick();
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto", proto_err, 0);
    reset_n = 1'b1;
    tick();

    do_cmd("add_ff_01", add_op, 8'hFF, 8'h01, 1, 16'h0100);
    do_cmd("mul_ff_ff", mul_op, 8'hFF, 8'hFF, MUL_LATENCY, 16'hFE01);
    do_cmd("and_f0_3c", and_op, 8'hF0, 8'h3C, 1, 16'h0030);
    do_cmd("xor_f0_3c", xor_op, 8'hF0, 8'h3C, 1, 16'h00CC);
    do_cmd("add_again", add_op, 8'hFF, 8'h01, 1, 16'h0100);
    do_cmd("no_op",     no_op,  8'h12, 8'h34, 1, 16'h0100);
    do_cmd("op_110",    op_t'(3'b110), 8'h55, 8'hAA, 1, 16'h0100);
    chk("proto_clean", proto_err, 0);

    // start held high for 5 cycles after done
    op = add_op; A = 8'h02; B = 8'h03; start = 1'b1;
    tick();
    tick();
    chk("hold_done", done, 1);
    chk("hold_result", result, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_no_2nd_done", done, 0);
      chk("hold_busy", busy, 1);
    end
    start = 1'b0;
    tick();
    chk("hold_busy_drop", busy, 0);
    tick();
    chk("hold_still_idle", busy, 0);
    do_cmd("after_hold", xor_op, 8'h0F, 8'h01, 1, 16'h000E);

    // reset in the middle of a multiply
    op = mul_op; A = 8'h10; B = 8'h10; start = 1'b1;
    tick();                                   // E0
    tick();                                   // E1
    reset_n = 1'b0; start = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < MUL_LATENCY + 1; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    reset_n = 1'b1;
    tick();
    chk("abort_result_after", result, 0);
    do_cmd("add_2_3", add_op, 8'h02, 8'h03, 1, 16'h0005);

    // operand changed mid multiply: result uses captured A, proto_err sticks
    op = mul_op; A = 8'h02; B = 8'h03; start = 1'b1;
    tick();                                   // E0
    chk("proto_pre", proto_err, 0);
    A = 8'h07;
    tick();
    chk("proto_set", proto_err, 1);
    tick();
    tick();                                   // E3
    chk("proto_done", done, 1);
    chk("proto_result", result, 16'h0006);
    start = 1'b0;
    tick();
    tick();
    do_cmd("proto_next", and_op, 8'hFF, 8'h0F, 1, 16'h000F);
    chk("proto_sticky", proto_err, 1);
    reset_n = 1'b0;
    #1;
    chk("proto_cleared", proto_err, 0);
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
